// File: rtl/conv_pkg.sv
// Shared definitions for the code-converter scheduler: mode codes,
// FSM state encoding and datapath widths.
package conv_pkg;

    localparam int DATA_W = 4;
    localparam int RES_W  = 7;
    localparam int MODE_W = 2;
    localparam int CNT_W  = 3;

    localparam logic [1:0] MODE_BCD  = 2'd0;
    localparam logic [1:0] MODE_GRAY = 2'd1;
    localparam logic [1:0] MODE_HAM  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request bit
// found searching ptr+1, ptr+2, ... (mod N_REQ). Outputs a one-hot grant,
// the encoded winner id and a flag that some request was present.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_vld
);

    int               idx_s;
    logic [N_REQ-1:0] onehot_s;

    // Walk from lowest to highest priority so the highest-priority hit is written last
    always_comb begin
        gnt      = '0;
        gnt_id   = '0;
        gnt_vld  = 1'b0;
        idx_s    = 0;
        onehot_s = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx_s    = ((int'(ptr) + k) >= N_REQ) ? (int'(ptr) + k - N_REQ) : (int'(ptr) + k);
            onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << idx_s;
            if (|(req & onehot_s)) begin
                gnt     = onehot_s;
                gnt_id  = ID_W'(idx_s);
                gnt_vld = 1'b1;
            end else begin
                gnt_vld = gnt_vld;
            end
        end
    end

endmodule

// File: rtl/conv_sched.sv
// Round-robin scheduler sharing one code-converter bank among N_REQ
// requesters. A granted request drives the bank, waits its fixed latency,
// then returns the captured result tagged with the requester id.
// Reserved mode skips the bank and answers with an error flag.
module conv_sched
    import conv_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int CONV_LAT = 1,
    parameter int ID_W     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [4*N_REQ-1:0]    req_data,
    input  logic [2*N_REQ-1:0]    req_mode,
    output logic [N_REQ-1:0]      ack,
    output logic [DATA_W-1:0]     bin_nat,
    output logic [MODE_W-1:0]     conv_sel,
    input  logic [RES_W-1:0]      conv_result,
    output logic                  res_valid,
    output logic [ID_W-1:0]       res_id,
    output logic [RES_W-1:0]      res_data,
    output logic                  res_err,
    output logic                  busy
);

    localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(CONV_LAT);

    state_t             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_REQ-1:0]   ack_q;
    logic [DATA_W-1:0]  bin_nat_q;
    logic [MODE_W-1:0]  conv_sel_q;
    logic               res_valid_q;
    logic [ID_W-1:0]    res_id_q;
    logic [RES_W-1:0]   res_data_q;
    logic               res_err_q;
    logic               busy_q;

    logic [N_REQ-1:0]   gnt_oh_s;
    logic [ID_W-1:0]    gnt_id_s;
    logic               gnt_vld_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic [MODE_W-1:0]  sel_mode_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt_oh_s),
        .gnt_id  (gnt_id_s),
        .gnt_vld (gnt_vld_s)
    );

    // One-hot select of the winner's data and mode; other slices are masked off
    always_comb begin
        sel_data_s = '0;
        sel_mode_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_data_s = sel_data_s | (req_data[4*i +: 4] & {DATA_W{gnt_oh_s[i]}});
            sel_mode_s = sel_mode_s | (req_mode[2*i +: 2] & {MODE_W{gnt_oh_s[i]}});
        end
    end

    // Scheduler FSM, round-robin pointer and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PTR_INIT;
            id_q        <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            bin_nat_q   <= '0;
            conv_sel_q  <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld_s) begin
                        id_q   <= gnt_id_s;
                        ptr_q  <= gnt_id_s;
                        ack_q  <= gnt_oh_s;
                        busy_q <= 1'b1;
                        if (sel_mode_s == MODE_RSVD) begin
                            // bank untouched; RESP raises the error result next edge
                            state_q <= ST_RESP;
                        end else begin
                            bin_nat_q  <= sel_data_s;
                            conv_sel_q <= sel_mode_s;
                            cnt_q      <= LAT_INIT;
                            state_q    <= ST_WAIT;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        res_data_q  <= conv_result;
                        res_err_q   <= 1'b0;
                        res_id_q    <= id_q;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (!res_valid_q) begin
                        // reserved-mode entry: publish the error result
                        res_valid_q <= 1'b1;
                        res_id_q    <= id_q;
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                    end else begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack       = ack_q;
    assign bin_nat   = bin_nat_q;
    assign conv_sel  = conv_sel_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign busy      = busy_q;

endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Round-robin scheduler that shares one code-converter bank (natural binary → BCD / Gray / Hamming(7,4)) between N_REQ requesters.
- Per request it:
  - accepts one 4-bit binary word plus a mode;
  - drives the bank's bin_nat input and converter select;
  - waits the bank's fixed latency, then returns the 7-bit result tagged with the requester id.
- Sits between client logic and the existing converter modules. The external mux onto conv_result is steered by conv_sel.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- CONV_LAT, 1, cycles from bin_nat change to valid conv_result (0..7).
- ID_W, 2, width of requester id (≥ clog2(N_REQ)).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- req  in  N_REQ  per-requester request, held until ack.
- req_data  in  4*N_REQ  binary word per requester, slice i = [4i+3:4i].
- req_mode  in  2*N_REQ  mode per requester: 0 BCD, 1 Gray, 2 Hamming, 3 reserved.
- ack  out  N_REQ  one-cycle pulse on the granted requester's bit.
- bin_nat  out  4  word driven to the converter bank.
- conv_sel  out  2  converter select to the bank/result mux.
- conv_result  in  7  selected converter output; BCD and Gray are zero-extended.
- res_valid  out  1  one-cycle result strobe.
- res_id  out  ID_W  id of the requester the result belongs to.
- res_data  out  7  captured conversion result.
- res_err  out  1  reserved mode used; qualified by res_valid.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (reset = 0 at an edge):
  - state = IDLE; round-robin pointer = N_REQ-1, so req[0] has first priority.
  - ack, res_valid, res_err, busy, res_id, res_data, bin_nat, conv_sel all 0.
- All outputs are registered.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req bit is set at edge E0, grant the first set bit searching ptr+1, ptr+2, … (mod N_REQ).
  - Latch id, data and mode; ptr := id.
  - ack[id] = 1 for the single cycle after E0; busy = 1.
- After grant, mode 0–2:
  - bin_nat = data and conv_sel = mode from the cycle after E0.
  - cnt := CONV_LAT; state → WAIT.
- After grant, mode 3:
  - No converter access; bin_nat and conv_sel keep their previous values.
  - res_err := 1, res_data := 0; state → RESP.
  - res_valid appears 1 cycle after ack.
- WAIT: if cnt == 0, capture res_data := conv_result at this edge, res_err := 0, state → RESP; otherwise cnt decrements.
  - Capture edge = E0 + CONV_LAT + 1.
  - res_valid is high in cycle CONV_LAT+2 after E0.
- RESP:
  - res_valid = 1 for exactly one cycle, with res_id/res_data/res_err stable.
  - Next edge → IDLE; res_valid := 0, busy := 0.
  - res_id, res_data and res_err hold until the next result.
- Throughput: one conversion per CONV_LAT+3 cycles (grant, CONV_LAT+1 wait cycles, respond, back to IDLE). No new grant during WAIT or RESP.
- Requesters must drop req in the ack cycle. A req still high in IDLE afterwards is a new request and is ranked after the others.
- req changes while busy are ignored until IDLE.
- bin_nat and conv_sel hold their last value in IDLE.
- Reset mid-operation: the in-flight result is discarded, no res_valid is issued, and the pointer returns to N_REQ-1.
- req_data and req_mode of non-granted requesters are never sampled.

Decomposition:
- Package conv_pkg:
  - MODE_BCD = 2'd0, MODE_GRAY = 2'd1, MODE_HAM = 2'd2, MODE_RSVD = 2'd3;
  - state encoding IDLE/WAIT/RESP;
  - data width 4, result width 7.
- Sub-module rr_arbiter:
  - inputs: req vector, pointer;
  - outputs: one-hot grant and encoded id, combinational;
  - reused by later shared-resource blocks.

Test Plan (CONV_LAT=1, converter bank model attached):
- Reset held 3 cycles, then released → all outputs 0, busy 0; no ack while req = 0.
- req[1] = 1, data 4'd9, Gray → ack[1] in cycle 1; bin_nat = 9 and conv_sel = 1 from cycle 1; res_valid in cycle 3 with res_id = 1, res_data = 7'b0001101.
- req = 3'b111 held continuously from reset release → grants in order 0, 1, 2, 0, …, ack pulses spaced 4 cycles apart.
- req[2], mode 3, data 4'd5 → ack[2] in cycle 1; res_valid in cycle 2 with res_err = 1, res_data = 0, res_id = 2.
- req[0], BCD, data 4'd13; reset = 0 during WAIT → no res_valid; after release, req[0] and req[1] both set → req[0] granted first.
- Sweep req[0] through data 0..15 in each of modes 0/1/2 → every res_data matches the reference model (e.g. 13 BCD = 7'b0010011, 13 Hamming matches the model codeword).
